// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D main-memory arbiter: FSM state encoding,
// default widths and the mem_we values for write-back and read accesses.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 14;  // 16-bit word address, 4 words per line
  localparam int LINE_W_DEF  = 64;  // 4 x 16-bit words
  localparam int MEM_LAT_DEF = 4;   // legal range 1..15
  localparam int CNT_W       = 4;   // wide enough for MEM_LAT-1 up to 14

  // mem_we encodings
  localparam logic WB   = 1'b1;
  localparam logic READ = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_WB   = 3'd1,
    D_FILL = 3'd2,
    I_FILL = 3'd3,
    DONE   = 3'd4
  } state_t;

  // True in the states that drive a memory access
  function automatic logic is_access(input state_t s);
    return (s == D_WB) || (s == D_FILL) || (s == I_FILL);
  endfunction

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter that times one fixed-latency memory access.
// load has priority over dec; the counter never wraps below zero.
module mem_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Count register: reload at the start of each access, step down otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one main-memory port between the I-cache fill path and the
// D-cache miss path (optional dirty write-back followed by a fill).
// Requests are sampled only in IDLE; contention is resolved round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [LINE_W-1:0] i_line,
  // data side
  input  logic              d_req,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_line,
  output logic              d_rdy,
  output logic [LINE_W-1:0] d_line,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  // Counter reload value: an access lasts cnt+1 = MEM_LAT cycles
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t state;
  logic   last_d;     // 1 = most recent grant went to the D side
  logic   grant_any;
  logic   grant_d;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  // Grant decision and latency-counter control
  always_comb begin
    grant_any = i_req | d_req;
    // D wins when alone, or when both request and I was served last
    grant_d   = d_req & (~i_req | ~last_d);
    // Reload on every entry into an access state, including WB -> FILL
    cnt_load  = ((state == IDLE) && grant_any) || ((state == D_WB) && cnt_zero);
    cnt_dec   = is_access(state) && !cnt_load;
  end

  mem_lat_cnt #(
    .W(CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero)
  );

  // Main FSM with registered strobes and line capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= READ;
      i_rdy  <= 1'b0;
      d_rdy  <= 1'b0;
      i_line <= '0;
      d_line <= '0;
    end else begin
      // rdy strobes are single-cycle pulses
      i_rdy <= 1'b0;
      d_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            mem_en <= 1'b1;
            last_d <= grant_d;
            if (grant_d) begin
              if (d_dirty) begin
                state  <= D_WB;
                mem_we <= WB;
              end else begin
                state  <= D_FILL;
                mem_we <= READ;
              end
            end else begin
              state  <= I_FILL;
              mem_we <= READ;
            end
          end
        end
        D_WB: begin
          // write-back flows straight into the fill with no idle gap
          if (cnt_zero) begin
            state  <= D_FILL;
            mem_we <= READ;
          end
        end
        D_FILL: begin
          if (cnt_zero) begin
            d_line <= mem_rdata;
            d_rdy  <= 1'b1;
            mem_en <= 1'b0;
            state  <= DONE;
          end
        end
        I_FILL: begin
          if (cnt_zero) begin
            i_line <= mem_rdata;
            i_rdy  <= 1'b1;
            mem_en <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // requester drops req on this edge; nothing is sampled here
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= READ;
        end
      endcase
    end
  end

  // Memory address/data follow the live requester inputs for the current state
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      D_WB: begin
        mem_addr  = d_wb_addr;
        mem_wdata = d_wb_line;
      end
      D_FILL:  mem_addr = d_addr;
      I_FILL:  mem_addr = i_addr;
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

endmodule
